// File: rtl/npc_btb_gen_pkg.sv
// Shared types and helpers for the next-PC / BTB unit.
// Holds the 2-bit counter encoding and its saturating update function.
package npc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

  function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
    ctr_e r;
    r = ctr;
    case (ctr)
      SNT: r = taken ? WNT : SNT;
      WNT: r = taken ? WT  : SNT;
      WT:  r = taken ? ST  : WNT;
      ST:  r = taken ? ST  : WT;
      default: r = CTR_RESET;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/npc_btb_gen_if.sv
// Pipeline-facing bundle of the next-PC unit: IF outputs, ID/EX control-flow
// inputs, redirect outputs and performance counters.
interface npc_btb_gen_if #(parameter int XLEN = 32);
  logic            stall_f;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] npc;
  logic            pred_taken_f;
  logic            jal_d;
  logic [XLEN-1:0] jal_target;
  logic            br_valid_e;
  logic            branch_e;
  logic            pred_taken_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] branch_target;
  logic            jalr_e;
  logic [XLEN-1:0] jalr_target;
  logic            mispredict_e;
  logic            redirect_e;
  logic [31:0]     branch_cnt;
  logic [31:0]     mispred_cnt;

  modport master (
    output stall_f, jal_d, jal_target, br_valid_e, branch_e, pred_taken_e,
           pc_e, branch_target, jalr_e, jalr_target,
    input  pc_f, npc, pred_taken_f, mispredict_e, redirect_e,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  stall_f, jal_d, jal_target, br_valid_e, branch_e, pred_taken_e,
           pc_e, branch_target, jalr_e, jalr_target,
    output pc_f, npc, pred_taken_f, mispredict_e, redirect_e,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/npc_btb_gen_btb_table.sv
// Direct-mapped BTB: async lookup on the fetch PC, one update port driven by
// the EX-stage branch resolution (hit -> counter/target update, taken miss -> allocate).
module btb_table
  import npc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_hit_o,
  output logic            rd_taken_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic            wr_taken_i,
  input  logic [XLEN-1:0] wr_target_i
);
  localparam int TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  ctr_e               ctr_q    [ENTRIES];
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  logic [IDX-1:0]  rd_idx, wr_idx;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic            wr_hit;

  assign rd_idx = rd_pc_i[IDX+1:2];
  assign rd_tag = rd_pc_i[XLEN-1:IDX+2];
  assign wr_idx = wr_pc_i[IDX+1:2];
  assign wr_tag = wr_pc_i[XLEN-1:IDX+2];

  // Reads see pre-update contents; there is no write-to-read bypass.
  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken_o  = ctr_q[rd_idx][1];
  assign rd_target_o = target_q[rd_idx];
  assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (wr_en_i) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken_i);
      end else if (wr_taken_i) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= WT;
      end
    end
  end

  // Tag/target need no reset: they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (wr_en_i && wr_taken_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_i;
    end
  end

endmodule

// File: rtl/npc_btb_gen.sv
// IF-stage PC register with BTB-based prediction, EX-stage resolution and
// redirect priority, plus branch/mispredict performance counters.
module npc_btb_gen
  import npc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  npc_btb_gen_if.slave bus
);
  localparam int IDX = $clog2(BTB_ENTRIES);

  logic [XLEN-1:0] pc_q, pc_d, npc;
  logic [31:0]     br_cnt_q, mp_cnt_q;
  logic            hit, hit_taken, pred_taken_f;
  logic [XLEN-1:0] hit_target;
  logic            mispredict, redirect;

  btb_table #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES), .IDX(IDX)) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_pc_i     (pc_q),
    .rd_hit_o    (hit),
    .rd_taken_o  (hit_taken),
    .rd_target_o (hit_target),
    .wr_en_i     (bus.br_valid_e),
    .wr_pc_i     (bus.pc_e),
    .wr_taken_i  (bus.branch_e),
    .wr_target_i (bus.branch_target)
  );

  assign pred_taken_f = hit & hit_taken;
  assign mispredict   = bus.br_valid_e & (bus.branch_e != bus.pred_taken_e);
  assign redirect     = mispredict | bus.jalr_e;

  // Older instructions win: EX corrections, then ID jumps, then IF prediction.
  always_comb begin
    npc = pc_q + XLEN'(4);
    if (mispredict && bus.branch_e)  npc = bus.branch_target;
    else if (mispredict)             npc = bus.pc_e + XLEN'(4);
    else if (bus.jalr_e)             npc = bus.jalr_target;
    else if (bus.jal_d)              npc = bus.jal_target;
    else if (pred_taken_f)           npc = hit_target;
  end

  // An EX redirect must land even while the front end is stalled.
  always_comb begin
    pc_d = npc;
    if (!redirect && bus.stall_f) pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      pc_q     <= pc_d;
      br_cnt_q <= br_cnt_q + {31'd0, bus.br_valid_e};
      mp_cnt_q <= mp_cnt_q + {31'd0, mispredict};
    end
  end

  assign bus.pc_f         = pc_q;
  assign bus.npc          = npc;
  assign bus.pred_taken_f = pred_taken_f;
  assign bus.mispredict_e = mispredict;
  assign bus.redirect_e   = redirect;
  assign bus.branch_cnt   = br_cnt_q;
  assign bus.mispred_cnt  = mp_cnt_q;

endmodule

// File: tb/tb_npc_btb_gen.sv
// Directed bench for npc_btb_gen: reset, BTB allocate/train/alias, redirect
// priority against stall, PC wrap and asynchronous mid-stream reset.
module tb_npc_btb_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  npc_btb_gen_if #(.XLEN(32)) bus ();

  npc_btb_gen #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_f = 0; bus.jal_d = 0; bus.jal_target = '0;
    bus.br_valid_e = 0; bus.branch_e = 0; bus.pred_taken_e = 0;
    bus.pc_e = '0; bus.branch_target = '0; bus.jalr_e = 0; bus.jalr_target = '0;
  endtask

  task automatic go_to(input logic [31:0] a);
    bus.jal_d = 1; bus.jal_target = a;
    tick();
    bus.jal_d = 0;
    #1;
  endtask

  task automatic br_set(input logic [31:0] pc, input logic tk, input logic pr,
                        input logic [31:0] tgt);
    bus.br_valid_e = 1; bus.pc_e = pc; bus.branch_e = tk;
    bus.pred_taken_e = pr; bus.branch_target = tgt;
    #1;
  endtask

  task automatic br_clr();
    bus.br_valid_e = 0; bus.branch_e = 0; bus.pred_taken_e = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #2;
    // reset state
    chk("rst_pc", bus.pc_f, 32'h0);
    chk("rst_pred", bus.pred_taken_f, 1'b0);
    chk("rst_bcnt", bus.branch_cnt, 0);
    chk("rst_mcnt", bus.mispred_cnt, 0);
    chk("rst_npc", bus.npc, 32'h4);
    #6 rst_n = 1;

    // sequential fetch
    tick(); chk("seq_pc4", bus.pc_f, 32'h4);
    tick(); chk("seq_pc8", bus.pc_f, 32'h8);
    tick(); chk("seq_pc12", bus.pc_f, 32'hC);
    chk("seq_pred", bus.pred_taken_f, 1'b0);

    // first encounter of taken branch at 0x10 -> 0x40
    br_set(32'h10, 1, 0, 32'h40);
    chk("alloc_misp", bus.mispredict_e, 1'b1);
    chk("alloc_redir", bus.redirect_e, 1'b1);
    chk("alloc_npc", bus.npc, 32'h40);
    tick(); br_clr();
    chk("alloc_pc", bus.pc_f, 32'h40);
    chk("alloc_bcnt", bus.branch_cnt, 1);
    chk("alloc_mcnt", bus.mispred_cnt, 1);
    go_to(32'h10);
    chk("hit_pred", bus.pred_taken_f, 1'b1);
    chk("hit_npc", bus.npc, 32'h40);

    // not-taken twice with stale pred=1: ctr 10->01->00
    br_set(32'h10, 0, 1, 32'h40);
    chk("nt1_war_pred", bus.pred_taken_f, 1'b1);
    chk("nt1_npc", bus.npc, 32'h14);
    tick(); br_clr();
    chk("nt1_pc", bus.pc_f, 32'h14);
    chk("nt1_mcnt", bus.mispred_cnt, 2);
    go_to(32'h10);
    chk("wnt_pred", bus.pred_taken_f, 1'b0);
    chk("wnt_npc", bus.npc, 32'h14);
    br_set(32'h10, 0, 1, 32'h40);
    tick(); br_clr();
    chk("nt2_mcnt", bus.mispred_cnt, 3);
    // from 00 one taken stays not-taken; a second reaches 10 with new target
    br_set(32'h10, 1, 0, 32'h44); tick(); br_clr();
    go_to(32'h10);
    chk("snt_up1_pred", bus.pred_taken_f, 1'b0);
    br_set(32'h10, 1, 0, 32'h44); tick(); br_clr();
    go_to(32'h10);
    chk("snt_up2_pred", bus.pred_taken_f, 1'b1);
    chk("retarget_npc", bus.npc, 32'h44);
    chk("train_bcnt", bus.branch_cnt, 5);
    chk("train_mcnt", bus.mispred_cnt, 5);

    // everything at once with stall: taken mispredict wins
    bus.stall_f = 1;
    bus.jalr_e = 1; bus.jalr_target = 32'h90;
    bus.jal_d = 1;  bus.jal_target = 32'hA0;
    br_set(32'h20, 1, 0, 32'h80);
    chk("prio_npc", bus.npc, 32'h80);
    tick(); br_clr(); bus.jalr_e = 0; #1;
    chk("prio_pc", bus.pc_f, 32'h80);
    chk("prio_bcnt", bus.branch_cnt, 6);
    chk("jal_npc", bus.npc, 32'hA0);
    chk("jal_redir", bus.redirect_e, 1'b0);
    tick();
    chk("stall_hold_pc", bus.pc_f, 32'h80);
    bus.jalr_e = 1; #1;
    chk("jalr_npc", bus.npc, 32'h90);
    chk("jalr_misp", bus.mispredict_e, 1'b0);
    tick();
    chk("jalr_stall_pc", bus.pc_f, 32'h90);
    idle(); #1;

    // aliasing: 0x50 shares index with 0x10
    br_set(32'h50, 1, 0, 32'h200); tick(); br_clr();
    go_to(32'h10);
    chk("alias_miss", bus.pred_taken_f, 1'b0);
    chk("alias_npc", bus.npc, 32'h14);
    go_to(32'h50);
    chk("alias_hit", bus.pred_taken_f, 1'b1);
    chk("alias_tgt", bus.npc, 32'h200);
    for (int i = 0; i < 3; i++) begin
      br_set(32'h50, 1, 1, 32'h200);
      chk("sat_nomisp", bus.mispredict_e, 1'b0);
      tick(); br_clr();
    end
    br_set(32'h50, 0, 1, 32'h200); tick(); br_clr();
    go_to(32'h50);
    chk("sat_st_pred", bus.pred_taken_f, 1'b1);
    chk("sat_bcnt", bus.branch_cnt, 11);
    chk("sat_mcnt", bus.mispred_cnt, 8);

    // PC wrap
    go_to(32'hFFFF_FFFC);
    chk("wrap_npc", bus.npc, 32'h0);
    tick();
    chk("wrap_pc", bus.pc_f, 32'h0);

    // async reset between edges
    go_to(32'h50);
    chk("pre_rst_hit", bus.pred_taken_f, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("arst_pc", bus.pc_f, 32'h0);
    chk("arst_bcnt", bus.branch_cnt, 0);
    chk("arst_mcnt", bus.mispred_cnt, 0);
    #1 rst_n = 1;
    go_to(32'h50);
    chk("arst_btb_miss", bus.pred_taken_f, 1'b0);
    chk("arst_npc", bus.npc, 32'h54);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/npc_btb_gen.md
Name: npc_btb_gen

Overview:
- Parametrised successor to the pipeline's combinational next-PC selector.
- Owns the IF-stage PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts conditional branches in IF, resolves them in EX, and redirects on mispredict, JAL (ID) or JALR (EX).
- Keeps branch and mispredict performance counters.

Parameters:
- XLEN, 32, data/address width.
- BTB_ENTRIES, 16, BTB depth; power of two, >= 2. IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_f  in  1  hold the PC register (hazard unit).
- pc_f  out  XLEN  current fetch PC (registered).
- npc  out  XLEN  next-PC value (combinational).
- pred_taken_f  out  1  IF prediction for pc_f; piped to EX by the segment registers.
- jal_d  in  1  JAL in ID.
- jal_target  in  XLEN  JAL target.
- br_valid_e  in  1  conditional branch in EX.
- branch_e  in  1  actual branch outcome in EX (1 = taken).
- pred_taken_e  in  1  prediction made for the EX branch.
- pc_e  in  XLEN  PC of the EX instruction.
- branch_target  in  XLEN  EX branch target.
- jalr_e  in  1  JALR in EX.
- jalr_target  in  XLEN  JALR target.
- mispredict_e  out  1  EX branch outcome differs from its prediction (combinational).
- redirect_e  out  1  mispredict_e | jalr_e; hazard unit flushes F/D and D/E on it.
- branch_cnt  out  32  resolved branches since reset.
- mispred_cnt  out  32  mispredicted branches since reset.

Behaviour:
- Reset (async, rst_n=0):
  - pc_f=RESET_PC; all BTB valid bits 0; all counters 2'b01 (weakly not-taken).
  - branch_cnt=0, mispred_cnt=0.
  - Combinational outputs follow from this state.
- Lookup (combinational on pc_f):
  - idx=pc_f[IDX+1:2], tag=pc_f[XLEN-1:IDX+2].
  - hit = valid[idx] & tag match.
  - pred_taken_f = hit & ctr[idx][1].
- mispredict_e = br_valid_e & (branch_e != pred_taken_e).
- npc priority, highest first:
  1. mispredict_e & branch_e -> branch_target.
  2. mispredict_e & !branch_e -> pc_e+4.
  3. jalr_e -> jalr_target.
  4. jal_d -> jal_target.
  5. pred_taken_f -> btb_target[idx].
  6. otherwise pc_f+4.
- All +4 arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- PC register:
  - redirect_e=1: pc_f<=npc even when stall_f=1 (EX redirect beats stall).
  - Else stall_f=1: pc_f holds.
  - Else: pc_f<=npc.
- BTB update on clock edge when br_valid_e; index/tag taken from pc_e:
  - Hit: counter saturates up on taken, down on not-taken (00 and 11 stick); target rewritten with branch_target on taken.
  - Miss and taken: allocate (valid=1, tag, target=branch_target, ctr=2'b10); any previous entry is overwritten.
  - Miss and not-taken: no change.
- Same-cycle read/write of one index: the lookup sees the pre-update contents (write-after-read). No bypass.
- Perf counters:
  - branch_cnt += br_valid_e; mispred_cnt += mispredict_e.
  - Both wrap at 2^32; they increment regardless of stall_f.
- Latency:
  - Correct prediction: 0 bubbles.
  - Mispredict or JALR: 2 bubbles.
  - JAL: 1 bubble.
- JAL/JALR are never allocated in the BTB.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Decomposition:
- Package npc_pkg:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Function ctr_next(ctr, taken) for saturating update.
  - Constant CTR_RESET=WNT.
- Sub-module btb_table:
  - Valid/tag/target/counter arrays.
  - One async read port, one write port.
  - Async-low reset of valid and counters.
- The top level holds the PC register, next-PC mux, mispredict logic and perf counters.

Test Plan:
- Reset release with no branches, stall_f=0 -> pc_f sequence 0,4,8,12; pred_taken_f=0; counters 0.
- Branch at 0x10, taken to 0x40, first encounter (pred 0) -> mispredict_e=1, npc=0x40, entry allocated with ctr=10. Next fetch of 0x10 -> pred_taken_f=1, npc=0x40.
- Same branch resolved not-taken twice with pred=1 -> ctr 10->01->00 (first mispredict redirects npc=0x14). mispred_cnt increments on every mismatch.
- Same cycle: mispredict_e (taken, target 0x80), jalr_e, jal_d and stall_f=1 all asserted -> pc_f<=0x80 on next edge.
- Aliasing: branches 0x10 and 0x10+4*BTB_ENTRIES, both taken -> second overwrites the entry; a lookup of the first misses. Counters saturate at 11 after three taken outcomes.
- rst_n pulsed low between clock edges mid-stream -> pc_f=RESET_PC immediately; BTB hits cease; counters read 0.
